axis_measure_sequencer: RTL and testbench

- AXI-Lite master that runs one timed measurement window on the AXI-Stream measurer through the measurer's control port.
- One start pulse runs this sequence: optional CLEAR, START, wait a programmable number of cycles, STOP, then read back the 64-bit assertion and cycle counters.
- Sits beside the measurer. Host logic or a test kernel drives it in place of a software driver.

---
 rtl/axis_measure_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_axis_measure_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_measure_sequencer.sv
// axis_measure_sequencer: AXI-Lite master that runs one timed measurement
// window on the stream measurer (optional CLEAR, START, wait, STOP) and then
// reads back the 64-bit assertion and cycle counters.
module axis_measure_sequencer #(
  parameter int ADDR_WIDTH        = 32,
  parameter int CONTROL_OFFSET    = 16,
  parameter int ASSERTIONS_OFFSET = 20,
  parameter int CYCLES_OFFSET     = 28,
  parameter int TIMEOUT           = 1024
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  start,
  input  logic                  clear_first,
  input  logic [31:0]           window_cycles,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [63:0]           result_assertions,
  output logic [63:0]           result_cycles,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  output logic [31:0]           m_axi_wdata,
  output logic [3:0]            m_axi_wstrb,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  input  logic [1:0]            m_axi_bresp,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  input  logic [31:0]           m_axi_rdata,
  input  logic [1:0]            m_axi_rresp
);

  typedef enum logic [3:0] {
    IDLE, WR_CLEAR, WR_START, WAIT, WR_STOP,
    RD_ALO, RD_AHI, RD_CLO, RD_CHI, DONE
  } state_t;

  state_t state_reg, state_next;

  // Per-state progress flags: which handshakes of the current transaction are finished.
  logic aw_done_reg, w_done_reg, ar_done_reg;
  logic [31:0] wait_cnt_reg;
  logic [31:0] phase_cnt_reg;
  logic [31:0] window_reg;
  logic        error_reg;
  logic [63:0] result_assertions_reg, result_cycles_reg;
  logic [ADDR_WIDTH-1:0] awaddr_reg, araddr_reg;
  logic [31:0] wdata_reg;

  logic is_wr, is_rd;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic phase_ok, timeout;

  // Decode which kind of transaction the current state performs.
  always_comb begin
    is_wr = (state_reg == WR_CLEAR) || (state_reg == WR_START) || (state_reg == WR_STOP);
    is_rd = (state_reg == RD_ALO) || (state_reg == RD_AHI) ||
            (state_reg == RD_CLO) || (state_reg == RD_CHI);
  end

  // Valids are high from the first cycle of a state until their own handshake;
  // they come straight from registered state so a reset drops them at once.
  assign m_axi_awvalid = is_wr && !aw_done_reg;
  assign m_axi_wvalid  = is_wr && !w_done_reg;
  assign m_axi_bready  = is_wr && aw_done_reg && w_done_reg;
  assign m_axi_arvalid = is_rd && !ar_done_reg;
  assign m_axi_rready  = is_rd && ar_done_reg;
  assign m_axi_awaddr  = awaddr_reg;
  assign m_axi_araddr  = araddr_reg;
  assign m_axi_wdata   = wdata_reg;
  assign m_axi_wstrb   = 4'hF;

  assign aw_hs = m_axi_awvalid && m_axi_awready;
  assign w_hs  = m_axi_wvalid  && m_axi_wready;
  assign b_hs  = m_axi_bvalid  && m_axi_bready;
  assign ar_hs = m_axi_arvalid && m_axi_arready;
  assign r_hs  = m_axi_rvalid  && m_axi_rready;

  assign busy              = (state_reg != IDLE) && (state_reg != DONE);
  assign done              = (state_reg == DONE);
  assign error             = error_reg;
  assign result_assertions = result_assertions_reg;
  assign result_cycles     = result_cycles_reg;

  // Detect completion of the current handshake phase (AW/W, B, AR or R) and
  // flag a timeout when the phase is on its last allowed cycle without completing.
  always_comb begin
    phase_ok = 1'b0;
    if (is_wr) begin
      if (aw_done_reg && w_done_reg)
        phase_ok = b_hs;
      else
        phase_ok = (aw_done_reg || aw_hs) && (w_done_reg || w_hs);
    end else if (is_rd) begin
      phase_ok = ar_done_reg ? r_hs : ar_hs;
    end
    timeout = (is_wr || is_rd) && !phase_ok && (phase_cnt_reg == 32'(TIMEOUT - 1));
  end

  // Next-state logic: walk the fixed transaction order, bail to DONE on timeout.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (start) state_next = clear_first ? WR_CLEAR : WR_START;
      WR_CLEAR: if (timeout) state_next = DONE;
                else if (b_hs) state_next = WR_START;
      WR_START: if (timeout) state_next = DONE;
                else if (b_hs) state_next = (window_reg == 32'd0) ? WR_STOP : WAIT;
      WAIT:     if (wait_cnt_reg == window_reg - 32'd1) state_next = WR_STOP;
      WR_STOP:  if (timeout) state_next = DONE;
                else if (b_hs) state_next = RD_ALO;
      RD_ALO:   if (timeout) state_next = DONE;
                else if (r_hs) state_next = RD_AHI;
      RD_AHI:   if (timeout) state_next = DONE;
                else if (r_hs) state_next = RD_CLO;
      RD_CLO:   if (timeout) state_next = DONE;
                else if (r_hs) state_next = RD_CHI;
      RD_CHI:   if (timeout) state_next = DONE;
                else if (r_hs) state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state_reg <= IDLE;
    else           state_reg <= state_next;
  end

  // Handshake progress flags, cleared whenever the state changes.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
      ar_done_reg <= 1'b0;
    end else if (state_next != state_reg) begin
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
      ar_done_reg <= 1'b0;
    end else begin
      if (aw_hs) aw_done_reg <= 1'b1;
      if (w_hs)  w_done_reg  <= 1'b1;
      if (ar_hs) ar_done_reg <= 1'b1;
    end
  end

  // Phase watchdog: counts cycles spent waiting in the current handshake phase.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)
      phase_cnt_reg <= 32'd0;
    else if ((state_next != state_reg) || phase_ok)
      phase_cnt_reg <= 32'd0;
    else if (is_wr || is_rd)
      phase_cnt_reg <= phase_cnt_reg + 32'd1;
  end

  // Window counter: zeroed by the START write response, counts every WAIT cycle.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)
      wait_cnt_reg <= 32'd0;
    else if ((state_reg == WR_START) && b_hs)
      wait_cnt_reg <= 32'd0;
    else if (state_reg == WAIT)
      wait_cnt_reg <= wait_cnt_reg + 32'd1;
  end

  // Sequence parameters and sticky error; error is only cleared by an accepted start.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      window_reg <= 32'd0;
      error_reg  <= 1'b0;
    end else if ((state_reg == IDLE) && start) begin
      window_reg <= window_cycles;
      error_reg  <= 1'b0;
    end else if ((b_hs && (m_axi_bresp != 2'b00)) ||
                 (r_hs && (m_axi_rresp != 2'b00)) || timeout) begin
      error_reg <= 1'b1;
    end
  end

  // Results only change on read-data handshakes, one 32-bit half per read state.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      result_assertions_reg <= 64'd0;
      result_cycles_reg     <= 64'd0;
    end else if (r_hs) begin
      case (state_reg)
        RD_ALO:  result_assertions_reg[31:0]  <= m_axi_rdata;
        RD_AHI:  result_assertions_reg[63:32] <= m_axi_rdata;
        RD_CLO:  result_cycles_reg[31:0]      <= m_axi_rdata;
        RD_CHI:  result_cycles_reg[63:32]     <= m_axi_rdata;
        default: ;
      endcase
    end
  end

  // Address/data loaded on entry to each transaction state and held until the
  // next one, so the slave may sample wdata late without seeing it change.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      awaddr_reg <= '0;
      araddr_reg <= '0;
      wdata_reg  <= 32'd0;
    end else if (state_next != state_reg) begin
      case (state_next)
        WR_CLEAR: begin awaddr_reg <= ADDR_WIDTH'(CONTROL_OFFSET); wdata_reg <= 32'd2; end
        WR_START: begin awaddr_reg <= ADDR_WIDTH'(CONTROL_OFFSET); wdata_reg <= 32'd1; end
        WR_STOP:  begin awaddr_reg <= ADDR_WIDTH'(CONTROL_OFFSET); wdata_reg <= 32'd0; end
        RD_ALO:   araddr_reg <= ADDR_WIDTH'(ASSERTIONS_OFFSET);
        RD_AHI:   araddr_reg <= ADDR_WIDTH'(ASSERTIONS_OFFSET + 4);
        RD_CLO:   araddr_reg <= ADDR_WIDTH'(CYCLES_OFFSET);
        RD_CHI:   araddr_reg <= ADDR_WIDTH'(CYCLES_OFFSET + 4);
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_measure_sequencer.sv
// Bench for axis_measure_sequencer: an AXI-Lite slave with configurable
// stalls and error responses, plus a transaction-level model of the
// expected write/read sequence, results, error flag and timing.
module tb_axis_measure_sequencer;
  localparam int TIMEOUT = 1024;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        start = 1'b0;
  logic        clear_first = 1'b0;
  logic [31:0] window_cycles = 32'd0;
  logic        busy, done, error;
  logic [63:0] result_assertions, result_cycles;
  logic        m_axi_awvalid, m_axi_awready;
  logic [31:0] m_axi_awaddr;
  logic        m_axi_wvalid, m_axi_wready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_bvalid, m_axi_bready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_arvalid, m_axi_arready;
  logic [31:0] m_axi_araddr;
  logic        m_axi_rvalid, m_axi_rready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;

  axis_measure_sequencer dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start(start), .clear_first(clear_first),
    .window_cycles(window_cycles), .busy(busy), .done(done), .error(error),
    .result_assertions(result_assertions), .result_cycles(result_cycles),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
    .m_axi_wstrb(m_axi_wstrb), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_bresp(m_axi_bresp), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_araddr(m_axi_araddr), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp)
  );

  initial forever #5 ap_clk = ~ap_clk;

  int cyc = 0;
  always @(posedge ap_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave configuration (written only by the main process).
  int          seq_id = 0;
  bit          rand_mode = 1'b0;
  int          aw_stall_cfg = 0;
  bit          b_never = 1'b0;
  int          bresp_err_idx = -1;
  int          rresp_err_idx = -1;
  logic [31:0] rd_val [4];

  // Observations (written only by the slave process).
  logic [31:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  logic [31:0] wr_hsdata_q [$];
  logic [31:0] rd_addr_q [$];
  int          start_b_cyc, stop_aw_cyc, done_cnt, done_cyc;
  bit          busy_at_done, err_at_done, w_first_seen;
  logic [4:0]  hs_at_done;

  function automatic logic [31:0] rd_lookup(input logic [31:0] a);
    case (a)
      32'd20:  return rd_val[0];
      32'd24:  return rd_val[1];
      32'd28:  return rd_val[2];
      32'd32:  return rd_val[3];
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  // Slave + monitor: at each falling edge, account for handshakes that took
  // place at the previous rising edge, then drive responses for the next one.
  initial begin : slave
    int aw_stall_left, b_delay, r_delay, seen_seq, wr_cnt, rd_cnt;
    bit aw_got, w_got, b_pend, r_pend;
    logic [31:0] aw_addr_s, w_data_s, ar_addr_s, p_awaddr, p_wdata, p_araddr;
    bit p_awv, p_awr, p_wv, p_wr, p_bv, p_br, p_arv, p_arr, p_rv, p_rr;
    seen_seq = 0; aw_stall_left = 0; b_delay = 0; r_delay = 0; wr_cnt = 0; rd_cnt = 0;
    aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
    aw_addr_s = 0; w_data_s = 0; ar_addr_s = 0; p_awaddr = 0; p_wdata = 0; p_araddr = 0;
    {p_awv, p_awr, p_wv, p_wr, p_bv, p_br, p_arv, p_arr, p_rv, p_rr} = '0;
    start_b_cyc = -1; stop_aw_cyc = -1; done_cnt = 0; done_cyc = 0;
    busy_at_done = 0; err_at_done = 0; w_first_seen = 0; hs_at_done = 0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
    forever begin
      @(negedge ap_clk);
      if (seen_seq != seq_id) begin
        seen_seq = seq_id;
        wr_addr_q.delete(); wr_data_q.delete(); wr_hsdata_q.delete(); rd_addr_q.delete();
        start_b_cyc = -1; stop_aw_cyc = -1; done_cnt = 0; w_first_seen = 0;
        wr_cnt = 0; rd_cnt = 0; aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
        aw_stall_left = aw_stall_cfg;
        m_axi_bvalid = 0; m_axi_rvalid = 0;
      end
      if (!ap_rst_n) begin
        aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rresp = 0;
        {p_awv, p_awr, p_wv, p_wr, p_bv, p_br, p_arv, p_arr, p_rv, p_rr} = '0;
      end else begin
        if (p_bv && p_br) begin
          wr_addr_q.push_back(aw_addr_s);
          wr_data_q.push_back(w_data_s);
          wr_hsdata_q.push_back(p_wdata);
          if (p_wdata == 32'd1) start_b_cyc = cyc - 1;
          wr_cnt++; aw_got = 0; w_got = 0; b_pend = 0; m_axi_bvalid = 0;
        end
        if (p_wv && p_wr) begin
          if (!aw_got && !(p_awv && p_awr)) w_first_seen = 1;
          w_got = 1;
        end
        if (p_awv && p_awr) begin
          aw_got = 1; aw_addr_s = p_awaddr;
          w_data_s = m_axi_wdata;  // slave samples data one cycle after AW
        end
        if (aw_got && w_got && !b_pend) begin
          b_pend = 1; b_delay = rand_mode ? int'($urandom_range(0, 3)) : 0;
        end
        if (p_rv && p_rr) begin
          rd_addr_q.push_back(ar_addr_s); rd_cnt++; r_pend = 0; m_axi_rvalid = 0;
        end
        if (p_arv && p_arr) begin
          ar_addr_s = p_araddr; r_pend = 1;
          r_delay = rand_mode ? int'($urandom_range(0, 3)) : 0;
        end
        if (b_pend && !m_axi_bvalid && !b_never) begin
          if (b_delay == 0) begin
            m_axi_bvalid = 1'b1;
            m_axi_bresp = (wr_cnt == bresp_err_idx) ? 2'b10 : 2'b00;
          end else b_delay--;
        end
        if (r_pend && !m_axi_rvalid) begin
          if (r_delay == 0) begin
            m_axi_rvalid = 1'b1;
            m_axi_rdata = rd_lookup(ar_addr_s);
            m_axi_rresp = (rd_cnt == rresp_err_idx) ? 2'b10 : 2'b00;
          end else r_delay--;
        end
        if (m_axi_awvalid && aw_stall_left > 0) begin
          m_axi_awready = 1'b0; aw_stall_left--;
        end else m_axi_awready = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
        m_axi_wready  = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
        m_axi_arready = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (m_axi_awvalid && m_axi_wdata == 32'd0 && stop_aw_cyc < 0) stop_aw_cyc = cyc;
        if (done) begin
          done_cnt++; done_cyc = cyc; busy_at_done = busy; err_at_done = error;
          hs_at_done = {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready};
        end
        p_awv = m_axi_awvalid; p_awr = m_axi_awready; p_awaddr = m_axi_awaddr;
        p_wv = m_axi_wvalid; p_wr = m_axi_wready; p_wdata = m_axi_wdata;
        p_bv = m_axi_bvalid; p_br = m_axi_bready;
        p_arv = m_axi_arvalid; p_arr = m_axi_arready; p_araddr = m_axi_araddr;
        p_rv = m_axi_rvalid; p_rr = m_axi_rready;
      end
    end
  end

  int          start_cyc = 0;
  logic [63:0] prev_a = 64'd0, prev_c = 64'd0;

  task automatic begin_seq(input bit cf, input logic [31:0] win);
    seq_id++;
    @(negedge ap_clk);
    @(negedge ap_clk);
    clear_first = cf; window_cycles = win; start = 1'b1; start_cyc = cyc;
    @(negedge ap_clk);
    start = 1'b0;
    check_eq("busy_after_start", 64'(busy), 64'd1);
    check_eq("error_cleared_on_start", 64'(error), 64'd0);
  endtask

  task automatic finish_seq(input bit cf, input logic [31:0] win, input bit exp_to);
    int waited;
    int exp_w [$];
    logic [31:0] exp_r [4];
    logic [63:0] exp_a, exp_c;
    bit exp_e;
    int nr;
    waited = 0;
    while (done_cnt == 0 && waited < 3000) begin
      @(negedge ap_clk);
      waited++;
    end
    repeat (3) @(negedge ap_clk);
    check_eq("done_pulse_count", 64'(done_cnt), 64'd1);
    if (!exp_to) begin
      if (cf) exp_w.push_back(2);
      exp_w.push_back(1);
      exp_w.push_back(0);
    end
    check_eq("write_count", 64'(wr_data_q.size()), 64'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < wr_data_q.size(); i++) begin
      check_eq("write_addr", 64'(wr_addr_q[i]), 64'd16);
      check_eq("write_data_sampled", 64'(wr_data_q[i]), 64'(exp_w[i]));
      check_eq("write_data_at_b", 64'(wr_hsdata_q[i]), 64'(exp_w[i]));
    end
    exp_r[0] = 32'd20; exp_r[1] = 32'd24; exp_r[2] = 32'd28; exp_r[3] = 32'd32;
    nr = exp_to ? 0 : 4;
    check_eq("read_count", 64'(rd_addr_q.size()), 64'(nr));
    for (int i = 0; i < nr && i < rd_addr_q.size(); i++)
      check_eq("read_addr", 64'(rd_addr_q[i]), 64'(exp_r[i]));
    exp_a = exp_to ? prev_a : {rd_val[1], rd_val[0]};
    exp_c = exp_to ? prev_c : {rd_val[3], rd_val[2]};
    check_eq("result_assertions", result_assertions, exp_a);
    check_eq("result_cycles", result_cycles, exp_c);
    exp_e = exp_to || (bresp_err_idx >= 0 && bresp_err_idx < exp_w.size()) ||
            (rresp_err_idx >= 0 && rresp_err_idx < 4);
    check_eq("error_at_done", 64'(err_at_done), 64'(exp_e));
    check_eq("error_held", 64'(error), 64'(exp_e));
    check_eq("busy_low_at_done", 64'(busy_at_done), 64'd0);
    check_eq("busy_idle", 64'(busy), 64'd0);
    if (!exp_to) begin
      check_eq("wait_window", 64'(stop_aw_cyc - start_b_cyc), 64'(win) + 64'd1);
      if (!rand_mode && aw_stall_cfg == 0)
        check_eq("zero_wait_latency", 64'(done_cyc - start_cyc),
                 64'(1 + 2 * exp_w.size() + 8) + 64'(win));
    end else begin
      check_eq("timeout_latency_ok",
               64'((done_cyc - start_cyc >= TIMEOUT + 1) && (done_cyc - start_cyc <= TIMEOUT + 3)), 64'd1);
      check_eq("timeout_handshakes_idle", 64'(hs_at_done), 64'd0);
    end
    prev_a = exp_a; prev_c = exp_c;
    $display("seq %0d: clear_first=%0d window=%0d writes=%0d reads=%0d error=%0d asrt=%0h cyc=%0h",
             seq_id, cf, win, wr_data_q.size(), rd_addr_q.size(), error, result_assertions, result_cycles);
  endtask

  task automatic run_seq(input bit cf, input logic [31:0] win, input bit exp_to);
    begin_seq(cf, win);
    finish_seq(cf, win, exp_to);
  endtask

  initial begin : main
    bit cf;
    logic [31:0] win;
    rd_val[0] = 0; rd_val[1] = 0; rd_val[2] = 0; rd_val[3] = 0;
    repeat (3) @(negedge ap_clk);
    check_eq("reset_valids", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}), 64'd0);
    check_eq("reset_status", 64'({busy, done, error}), 64'd0);
    check_eq("reset_results", result_assertions | result_cycles, 64'd0);
    check_eq("reset_addr_data", 64'(m_axi_awaddr | m_axi_araddr | m_axi_wdata), 64'd0);
    check_eq("wstrb", 64'(m_axi_wstrb), 64'hF);
    #2 ap_rst_n = 1'b1;

    // Directed: full sequence with CLEAR, 100-cycle window.
    rd_val[0] = 32'd5; rd_val[1] = 32'd0; rd_val[2] = 32'd104; rd_val[3] = 32'd0;
    run_seq(1'b1, 32'd100, 1'b0);
    check_eq("test1_assertions", result_assertions, 64'd5);
    check_eq("test1_cycles", result_cycles, 64'd104);

    // No CLEAR, zero window.
    rd_val[0] = 32'h11111111; rd_val[1] = 32'h22222222; rd_val[2] = 32'h33333333; rd_val[3] = 32'h44444444;
    run_seq(1'b0, 32'd0, 1'b0);

    // AW stalled 3 cycles while W is accepted at once.
    aw_stall_cfg = 3;
    run_seq(1'b0, 32'd4, 1'b0);
    check_eq("w_before_aw", 64'(w_first_seen), 64'd1);
    aw_stall_cfg = 0;

    // Error response on the last read.
    rd_val[3] = 32'hCAFE0001;
    rresp_err_idx = 3;
    run_seq(1'b1, 32'd3, 1'b0);
    rresp_err_idx = -1;
    repeat (4) @(negedge ap_clk);
    check_eq("error_sticky_idle", 64'(error), 64'd1);
    run_seq(1'b0, 32'd2, 1'b0);

    // B response never arrives: watchdog ends the sequence.
    b_never = 1'b1;
    run_seq(1'b0, 32'd5, 1'b1);
    b_never = 1'b0;

    // Reset pulsed in the middle of WAIT.
    begin_seq(1'b0, 32'd200);
    repeat (10) @(negedge ap_clk);
    check_eq("in_wait_busy", 64'({busy, m_axi_awvalid, m_axi_arvalid}), 64'b100);
    #2 ap_rst_n = 1'b0;
    #1;
    check_eq("midrst_valids", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}), 64'd0);
    check_eq("midrst_status", 64'({busy, done, error}), 64'd0);
    check_eq("midrst_results", result_assertions | result_cycles, 64'd0);
    check_eq("midrst_addr_data", 64'(m_axi_awaddr | m_axi_araddr | m_axi_wdata), 64'd0);
    prev_a = 64'd0; prev_c = 64'd0;
    @(negedge ap_clk);
    @(negedge ap_clk);
    #2 ap_rst_n = 1'b1;
    rd_val[0] = 32'd7; rd_val[1] = 32'd1; rd_val[2] = 32'd9; rd_val[3] = 32'd2;
    run_seq(1'b1, 32'd10, 1'b0);

    // Randomized slave timing, data and error responses.
    rand_mode = 1'b1;
    for (int n = 0; n < 10; n++) begin
      cf = 1'($urandom_range(0, 1));
      win = $urandom_range(0, 40);
      for (int k = 0; k < 4; k++) rd_val[k] = $urandom;
      bresp_err_idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1;
      rresp_err_idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      run_seq(cf, win, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
